// File: rtl/uart_boot_ctrl.sv
// UART boot loader: parses SYNC/LEN/payload/CHK frames from a byte stream.
// Writes the payload into instruction memory, then releases the CPU reset.
//
// Ports:
//   clk, reset_n         clock and async active-low reset
//   rx_valid, rx_byte    received UART byte strobe and data
//   mem_we/addr/wdata    byte write port into instruction memory
//   cpu_rstn             registered active-low CPU reset, high only in RUN
//   boot_state           current FSM state code (for LEDs)
//   boot_err             sticky error flag, cleared by the next good boot
module uart_boot_ctrl #(
    parameter int          MEM_BYTES   = 1024,
    parameter int          TIMEOUT_CYC = 1_000_000,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        cpu_rstn,
    output logic [2:0]  boot_state,
    output logic        boot_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC);
    localparam logic [16:0] MAXN = 17'(MEM_BYTES);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4,
        S_RUN    = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    state_t        state;
    logic [7:0]    len_lo;
    logic [15:0]   len;
    logic [15:0]   idx;
    logic [7:0]    sum;
    logic [TW-1:0] tcnt;

    logic [15:0] n_len;
    logic [15:0] idx_nxt;
    logic        in_frame;
    logic        tmo;
    logic        is_sync;

    assign n_len    = {rx_byte, len_lo};
    assign idx_nxt  = idx + 16'd1;
    assign is_sync  = rx_valid && (rx_byte == SYNC_BYTE);
    assign in_frame = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                      (state == S_DATA)   || (state == S_CSUM);
    // Idle cycle that would bring the gap count up to the limit.
    // A byte in the same cycle wins, since tmo requires !rx_valid.
    assign tmo = in_frame && !rx_valid && (tcnt != TMAX) &&
                 ((tcnt + TW'(1)) == TMAX);

    assign boot_state = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rstn  <= 1'b0;
            boot_err  <= 1'b0;
            len_lo    <= '0;
            len       <= '0;
            idx       <= '0;
            sum       <= '0;
            tcnt      <= '0;
        end else begin
            mem_we   <= 1'b0;
            // Lags the state by one cycle: rises after RUN entry, falls
            // the cycle after a re-sync leaves RUN.
            cpu_rstn <= (state == S_RUN);

            if (!in_frame || rx_valid) begin
                tcnt <= '0;
            end else if (tcnt != TMAX) begin
                tcnt <= tcnt + TW'(1);
            end

            unique case (state)
                S_IDLE: begin
                    if (is_sync) begin
                        state <= S_LEN_LO;
                        sum   <= '0;
                        idx   <= '0;
                    end
                end
                S_LEN_LO: begin
                    if (rx_valid) begin
                        len_lo <= rx_byte;
                        state  <= S_LEN_HI;
                    end else if (tmo) begin
                        state    <= S_ERROR;
                        boot_err <= 1'b1;
                    end
                end
                S_LEN_HI: begin
                    if (rx_valid) begin
                        if (n_len == 16'd0 || {1'b0, n_len} > MAXN) begin
                            state    <= S_ERROR;
                            boot_err <= 1'b1;
                        end else begin
                            len   <= n_len;
                            idx   <= '0;
                            sum   <= '0;
                            state <= S_DATA;
                        end
                    end else if (tmo) begin
                        state    <= S_ERROR;
                        boot_err <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= {16'd0, idx};
                        mem_wdata <= rx_byte;
                        sum       <= sum + rx_byte;
                        idx       <= idx_nxt;
                        if (idx_nxt == len) begin
                            state <= S_CSUM;
                        end
                    end else if (tmo) begin
                        state    <= S_ERROR;
                        boot_err <= 1'b1;
                    end
                end
                S_CSUM: begin
                    if (rx_valid) begin
                        if (rx_byte == sum) begin
                            state    <= S_RUN;
                            boot_err <= 1'b0;
                        end else begin
                            state    <= S_ERROR;
                            boot_err <= 1'b1;
                        end
                    end else if (tmo) begin
                        state    <= S_ERROR;
                        boot_err <= 1'b1;
                    end
                end
                S_RUN, S_ERROR: begin
                    if (is_sync) begin
                        state <= S_LEN_LO;
                        sum   <= '0;
                        idx   <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_boot_ctrl.sv
// Testbench for uart_boot_ctrl: directed frames, scoreboard on memory writes.
// Status outputs are checked inline by the stimulus process.
module tb_uart_boot_ctrl;

    localparam int TMO = 16;

    logic        clk;
    logic        reset_n;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_rstn;
    logic [2:0]  boot_state;
    logic        boot_err;

    int vectors;
    int miscompares;

    logic [39:0] exp_q[$];

    uart_boot_ctrl #(
        .MEM_BYTES  (1024),
        .TIMEOUT_CYC(TMO),
        .SYNC_BYTE  (8'hA5)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rstn  (cpu_rstn),
        .boot_state(boot_state),
        .boot_err  (boot_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_wr(input logic [31:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    // Called at a negedge; holds the byte for exactly one posedge.
    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Write monitor: every mem_we cycle must match the next expected write.
    always @(negedge clk) begin
        if (reset_n && mem_we) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                         mem_addr, mem_wdata);
            end else begin
                logic [39:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", mem_addr, e[39:8]);
                chk("wr_data", {24'd0, mem_wdata}, {24'd0, e[7:0]});
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        rx_valid    = 1'b0;
        rx_byte     = 8'h00;
        idle(3);
        chk("rst_state", {29'd0, boot_state}, 32'd0);
        chk("rst_cpu_rstn", {31'd0, cpu_rstn}, 32'd0);
        chk("rst_err", {31'd0, boot_err}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", {24'd0, mem_wdata}, 32'd0);
        reset_n = 1'b1;
        idle(2);

        // Noise in IDLE is ignored.
        send(8'h33);
        send(8'h04);
        chk("idle_noise", {29'd0, boot_state}, 32'd0);

        // Valid frame, back-to-back bytes.
        exp_wr(0, 8'h11); exp_wr(1, 8'h22);
        exp_wr(2, 8'h33); exp_wr(3, 8'h44);
        send(8'hA5); send(8'h04); send(8'h00);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        chk("csum_state", {29'd0, boot_state}, 32'd4);
        send(8'hAA);
        chk("run_state", {29'd0, boot_state}, 32'd5);
        idle(1);
        chk("run_cpu_rstn", {31'd0, cpu_rstn}, 32'd1);
        chk("run_err", {31'd0, boot_err}, 32'd0);

        // Non-sync byte in RUN ignored; sync re-enters LEN_LO.
        send(8'h12);
        chk("run_ignore", {29'd0, boot_state}, 32'd5);
        send(8'hA5);
        chk("resync_state", {29'd0, boot_state}, 32'd1);
        idle(1);
        chk("resync_cpu_rstn", {31'd0, cpu_rstn}, 32'd0);
        exp_wr(0, 8'h7F);
        send(8'h01); send(8'h00); send(8'h7F); send(8'h7F);
        chk("run2_state", {29'd0, boot_state}, 32'd5);
        idle(1);
        chk("run2_cpu_rstn", {31'd0, cpu_rstn}, 32'd1);

        // Bad checksum.
        exp_wr(0, 8'h01); exp_wr(1, 8'h02);
        send(8'hA5); send(8'h02); send(8'h00);
        send(8'h01); send(8'h02); send(8'h00);
        chk("badck_state", {29'd0, boot_state}, 32'd6);
        chk("badck_err", {31'd0, boot_err}, 32'd1);
        idle(1);
        chk("badck_cpu_rstn", {31'd0, cpu_rstn}, 32'd0);

        // Bad lengths: zero and MEM_BYTES+1.
        send(8'hA5); send(8'h00); send(8'h00);
        chk("len0_state", {29'd0, boot_state}, 32'd6);
        send(8'hA5); send(8'h01); send(8'h04);
        chk("len1025_state", {29'd0, boot_state}, 32'd6);
        chk("len1025_err", {31'd0, boot_err}, 32'd1);
        // Payload-looking bytes after the error write nothing.
        send(8'h55); send(8'h66);
        chk("err_ignore", {29'd0, boot_state}, 32'd6);

        // Sticky error stays through re-sync until RUN.
        send(8'hA5);
        chk("sticky_err", {31'd0, boot_err}, 32'd1);
        exp_wr(0, 8'h7F);
        send(8'h01); send(8'h00); send(8'h7F); send(8'h7F);
        chk("clr_err", {31'd0, boot_err}, 32'd0);
        chk("clr_state", {29'd0, boot_state}, 32'd5);

        // Timeout: a byte after 15 idle cycles survives, 16 idle cycles do not.
        exp_wr(0, 8'h01); exp_wr(1, 8'h02);
        send(8'hA5); send(8'h03); send(8'h00); send(8'h01);
        idle(TMO - 1);
        send(8'h02);
        chk("tmo_survive", {29'd0, boot_state}, 32'd3);
        idle(TMO - 1);
        chk("tmo_edge", {29'd0, boot_state}, 32'd3);
        idle(1);
        chk("tmo_state", {29'd0, boot_state}, 32'd6);
        chk("tmo_err", {31'd0, boot_err}, 32'd1);

        // Reset mid-DATA.
        exp_wr(0, 8'h10);
        send(8'hA5); send(8'h03); send(8'h00); send(8'h10);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_state", {29'd0, boot_state}, 32'd0);
        chk("arst_cpu_rstn", {31'd0, cpu_rstn}, 32'd0);
        chk("arst_we", {31'd0, mem_we}, 32'd0);
        chk("arst_err", {31'd0, boot_err}, 32'd0);
        #1 reset_n = 1'b1;
        @(negedge clk);
        send(8'h20); send(8'h30);
        idle(2);
        chk("post_rst_state", {29'd0, boot_state}, 32'd0);

        idle(2);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_boot_ctrl.md
UART_BOOT_CTRL -- requirements
Module: uart_boot_ctrl

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1024, meaning the instruction-memory size in bytes and the maximum payload length.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1_000_000, meaning the maximum number of clk cycles allowed between bytes inside a frame.
REQ-003 SHALL have parameter SYNC_BYTE, default 8'hA5, meaning the frame start marker.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port rx_valid, input, 1 bit: one-cycle strobe marking a received UART byte.
REQ-007 SHALL have port rx_byte, input, 8 bits: received byte, valid only while rx_valid=1.
REQ-008 SHALL have port mem_we, output, 1 bit: byte write strobe to CPU instruction memory.
REQ-009 SHALL have port mem_addr, output, 32 bits: byte address of the write.
REQ-010 SHALL have port mem_wdata, output, 8 bits: byte to write.
REQ-011 SHALL have port cpu_rstn, output, 1 bit: active-low CPU reset, high only in RUN.
REQ-012 SHALL have port boot_state, output, 3 bits: encoded FSM state, used for LEDs.
REQ-013 SHALL have port boot_err, output, 1 bit: sticky error flag, set on entry to ERROR.

Function
REQ-014 SHALL implement frame format: SYNC_BYTE, LEN_LO, LEN_HI (16-bit little-endian byte count N), N payload bytes, then CHK = 8-bit sum of the payload mod 256.
REQ-015 SHALL use states IDLE=0, LEN_LO=1, LEN_HI=2, DATA=3, CSUM=4, RUN=5, ERROR=6, and boot_state SHALL equal the current state code.
REQ-016 SHALL make the following transitions, each on a byte (rx_valid=1):
- IDLE: byte==SYNC_BYTE goes to LEN_LO; any other byte is ignored.
- LEN_LO: captures the low length byte and goes to LEN_HI.
- LEN_HI: forms N; N==0 or N>MEM_BYTES goes to ERROR; otherwise goes to DATA.
REQ-017 SHALL, for each byte accepted in DATA, pulse mem_we for exactly one cycle on the following cycle, with mem_wdata=byte and mem_addr=payload index (0..N-1, zero-extended to 32 bits).
REQ-018 SHALL keep mem_addr and mem_wdata stable while mem_we=1.
REQ-019 SHALL, in DATA, accumulate the 8-bit checksum with wrap-around and go to CSUM after the Nth payload byte.
REQ-020 SHALL, in CSUM, go to RUN if the received byte equals the accumulated sum, otherwise go to ERROR.
REQ-021 SHALL drive cpu_rstn=0 in every state except RUN and drive it from a register, giving no glitches; cpu_rstn SHALL rise in the cycle after entry into RUN.
REQ-022 SHALL, in RUN or ERROR, on byte==SYNC_BYTE, go to LEN_LO, drive cpu_rstn=0 from the next cycle, and clear the checksum, index and timeout counter; any other byte is ignored.
REQ-023 SHALL leave boot_err at 1 after re-sync until the following successful entry into RUN, which clears it.
REQ-024 SHALL, in LEN_LO, LEN_HI, DATA and CSUM, count cycles without rx_valid, reset the count on every rx_valid, and go to ERROR when the count reaches TIMEOUT_CYC.
REQ-025 SHALL give precedence to a byte over a timeout when both occur in the same cycle.
REQ-026 SHALL saturate the timeout counter, and its width SHALL be $clog2(TIMEOUT_CYC+1).
REQ-027 SHALL NOT generate memory writes outside the DATA state; a frame aborted by ERROR leaves the bytes already written in memory.
REQ-028 SHALL accept back-to-back rx_valid on consecutive cycles in every state without losing bytes.

Reset
REQ-029 SHALL, while reset_n=0 (applied asynchronously), force state=IDLE, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rstn=0, boot_err=0, checksum=0, index=0 and timeout count=0.
REQ-030 SHALL, on reset_n deassertion mid-frame, wait for a new SYNC_BYTE before accepting any frame data.

Verification
REQ-031 SHALL cover a valid frame: bytes A5 04 00 11 22 33 44 AA produce writes (0,11) (1,22) (2,33) (3,44), then state RUN, cpu_rstn=1 and boot_err=0.
REQ-032 SHALL cover a bad checksum: A5 02 00 01 02 00 produces two writes, then ERROR, boot_err=1 and cpu_rstn=0.
REQ-033 SHALL cover bad lengths: A5 00 00 and A5 01 04 (N=1025) each go to ERROR with no mem_we.
REQ-034 SHALL cover a timeout: A5 03 00 01 followed by TIMEOUT_CYC idle cycles (TIMEOUT_CYC=16 for sim) goes to ERROR; a byte arriving on cycle 15 keeps the frame in DATA.
REQ-035 SHALL cover re-sync from RUN: after the valid frame, sending A5 drops cpu_rstn the next cycle, and a second valid frame (A5 01 00 7F 7F) writes (0,7F) and returns to RUN.
REQ-036 SHALL cover reset mid-operation: reset_n pulsed low mid-DATA immediately gives IDLE, cpu_rstn=0 and mem_we=0; subsequent payload bytes without a leading A5 are ignored.
